// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side end of the SD CMD line (1-bit bus mode, 48-bit frames).
// Receives host commands sampled on SDCLK rising edges and reports index and argument.
// Sends R1/R3/R6/R7-style 48-bit responses on SDCLK falling edges.
// SDCLK and CMD are oversampled by clk_i, which must run at least 8x faster than SDCLK.
// Optional feature macro: SD_CMD_CRC_CHECK_EN enables the receive-side CRC7 check.
// When that check fails, the command is reported with cmd_crc_err_o=1 and no response is sent.
`timescale 1ns/1ps

module sd_cmd_responder #(
  parameter int NCR     = 2,  // SDCLK rises between the command end bit and the response start bit (2..64)
  parameter int SYNC_FF = 2   // synchroniser depth on sdclk_i and cmd_i (2..3)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sdclk_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        cmd_crc_err_o,
  output logic        resp_ready_o,
  input  logic        resp_valid_i,
  input  logic [5:0]  resp_index_i,
  input  logic [31:0] resp_arg_i,
  input  logic        resp_no_crc_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT_RESP,
    S_NCR,
    S_TX
  } state_e;

  localparam logic [6:0] NCR_LIM = 7'(NCR);

  // CRC7, polynomial x^7 + x^3 + 1, initial value 0, data MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Line synchronisers and edge strobes
  // ---------------------------------------------------------------------------
  logic [SYNC_FF-1:0] sdclk_sync_q;
  logic [SYNC_FF-1:0] cmd_sync_q;
  logic               sdclk_prev_q;
  logic               sdclk_s;
  logic               cmd_s;
  logic               sd_rise;
  logic               sd_fall;

  // Both chains have equal depth so the cmd sample lines up with its SDCLK edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and the register order inside the block is irrelevant.
    if (!rst_ni) begin
      sdclk_sync_q <= '0;
      cmd_sync_q   <= '1;
      sdclk_prev_q <= 1'b0;
    end else begin
      sdclk_sync_q <= {sdclk_sync_q[SYNC_FF-2:0], sdclk_i};
      cmd_sync_q   <= {cmd_sync_q[SYNC_FF-2:0], cmd_i};
      sdclk_prev_q <= sdclk_s;
    end
  end

  assign sdclk_s = sdclk_sync_q[SYNC_FF-1];
  assign cmd_s   = cmd_sync_q[SYNC_FF-1];
  assign sd_rise = sdclk_s & ~sdclk_prev_q;
  assign sd_fall = ~sdclk_s & sdclk_prev_q;

  // ---------------------------------------------------------------------------
  // Frame decode helpers
  // ---------------------------------------------------------------------------
  logic [47:0] rx_shift_q;
  logic        frame_ok;
  logic        rx_crc_bad;
  logic [39:0] resp_head;
  logic [6:0]  resp_crc;
  logic [47:0] resp_frame;
  state_e      state_q;

  // A frame is well formed when its transmission bit (46) and end bit (0) are both 1.
  assign frame_ok   = rx_shift_q[46] & rx_shift_q[0];
  assign resp_head  = {2'b00, resp_index_i, resp_arg_i};
  assign resp_crc   = resp_no_crc_i ? 7'h7F : crc7(resp_head);
  assign resp_frame = {resp_head, resp_crc, 1'b1};

`ifdef SD_CMD_CRC_CHECK_EN
  logic crc_err_q;

  assign rx_crc_bad = (crc7(rx_shift_q[47:8]) != rx_shift_q[7:1]);

  // The CRC flag is updated together with the index/argument of a well-formed frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_err_q <= 1'b0;
    end else if (state_q == S_CHECK && frame_ok) begin
      crc_err_q <= rx_crc_bad;
    end
  end

  assign cmd_crc_err_o = crc_err_q;
`else
  logic unused_rx_bits;

  assign rx_crc_bad     = 1'b0;
  assign cmd_crc_err_o  = 1'b0;
  assign unused_rx_bits = ^{rx_shift_q[47], rx_shift_q[7:1]};
`endif

  // ---------------------------------------------------------------------------
  // Protocol FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [5:0]  bit_cnt_q;
  logic [6:0]  ncr_cnt_q;
  logic [47:0] tx_shift_q;
  logic [5:0]  tx_cnt_q;
  logic        cmd_q;
  logic        cmd_oe_q;
  logic        valid_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  logic        ready_q;
  logic        busy_q;

  // Receive, check, wait for the response request, count NCR, then transmit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the shift registers are reset along with the control state so a
      // reset mid-frame can never leave stale frame bits behind.
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      ncr_cnt_q  <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      cmd_q      <= 1'b1;
      cmd_oe_q   <= 1'b0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sd_rise && !cmd_s) begin
            rx_shift_q <= {rx_shift_q[46:0], cmd_s};
            bit_cnt_q  <= 6'd1;
            state_q    <= S_RX;
            busy_q     <= 1'b1;
          end
        end

        S_RX: begin
          if (sd_rise) begin
            rx_shift_q <= {rx_shift_q[46:0], cmd_s};
            if (bit_cnt_q != 6'd48) bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd47) state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (frame_ok) begin
            index_q <= rx_shift_q[45:40];
            arg_q   <= rx_shift_q[39:8];
            valid_q <= 1'b1;
            if (rx_crc_bad) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_WAIT_RESP;
              ready_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_WAIT_RESP: begin
          // A new start bit means the host abandoned this command.
          if (sd_rise && !cmd_s) begin
            ready_q    <= 1'b0;
            rx_shift_q <= {rx_shift_q[46:0], cmd_s};
            bit_cnt_q  <= 6'd1;
            state_q    <= S_RX;
          end else if (resp_valid_i) begin
            ready_q    <= 1'b0;
            tx_shift_q <= resp_frame;
            ncr_cnt_q  <= '0;
            state_q    <= S_NCR;
          end
        end

        S_NCR: begin
          if (sd_rise && ncr_cnt_q < NCR_LIM) begin
            ncr_cnt_q <= ncr_cnt_q + 7'd1;
          end else if (sd_fall && ncr_cnt_q >= NCR_LIM) begin
            cmd_oe_q   <= 1'b1;
            cmd_q      <= tx_shift_q[47];
            tx_shift_q <= {tx_shift_q[46:0], 1'b0};
            tx_cnt_q   <= 6'd47;
            state_q    <= S_TX;
          end
        end

        S_TX: begin
          if (sd_fall) begin
            if (tx_cnt_q == 6'd0) begin
              cmd_oe_q <= 1'b0;
              cmd_q    <= 1'b1;
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
            end else begin
              cmd_q      <= tx_shift_q[47];
              tx_shift_q <= {tx_shift_q[46:0], 1'b0};
              tx_cnt_q   <= tx_cnt_q - 6'd1;
            end
          end
        end

        default: begin
          state_q  <= S_IDLE;
          cmd_oe_q <= 1'b0;
          cmd_q    <= 1'b1;
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_o        = cmd_q;
  assign cmd_oe_o     = cmd_oe_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_index_o  = index_q;
  assign cmd_arg_o    = arg_q;
  assign resp_ready_o = ready_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder: host-side bench for sd_cmd_responder.
// Drives command frames on SDCLK falls, reads responses on SDCLK rises.
// Expected frames come from a long-division CRC7 model and the frame layout.
// Build with SD_CMD_CRC_CHECK_EN defined to exercise the receive CRC check.
`timescale 1ns/1ps

module tb_sd_cmd_responder;

`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sdclk_i = 1'b0;
  logic        cmd_i = 1'b1;
  logic        cmd_o;
  logic        cmd_oe_o;
  logic        cmd_valid_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic        cmd_crc_err_o;
  logic        resp_ready_o;
  logic        resp_valid_i = 1'b0;
  logic [5:0]  resp_index_i = '0;
  logic [31:0] resp_arg_i = '0;
  logic        resp_no_crc_i = 1'b0;
  logic        busy_o;

  sd_cmd_responder #(.NCR(2), .SYNC_FF(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sdclk_i       (sdclk_i),
    .cmd_i         (cmd_i),
    .cmd_o         (cmd_o),
    .cmd_oe_o      (cmd_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_index_o   (cmd_index_o),
    .cmd_arg_o     (cmd_arg_o),
    .cmd_crc_err_o (cmd_crc_err_o),
    .resp_ready_o  (resp_ready_o),
    .resp_valid_i  (resp_valid_i),
    .resp_index_i  (resp_index_i),
    .resp_arg_i    (resp_arg_i),
    .resp_no_crc_i (resp_no_crc_i),
    .busy_o        (busy_o)
  );

  // 100 MHz system clock; SDCLK is 16x slower and its edges never meet a clk edge.
  always #5 clk_i = ~clk_i;
  initial begin
    #2.5;
    forever #80 sdclk_i = ~sdclk_i;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitors: counted events only, each written by exactly one process.
  int   rise_cnt    = 0;
  int   pulse_cnt   = 0;
  int   oe_rise_cnt = 0;
  int   oe_rise_at  = 0;
  logic cap_crc     = 1'b0;
  logic oe_prev     = 1'b0;

  always @(posedge sdclk_i) rise_cnt++;

  always @(negedge clk_i) begin
    if (cmd_valid_o) begin
      pulse_cnt++;
      cap_crc = cmd_crc_err_o;
    end
    if (cmd_oe_o && !oe_prev) begin
      oe_rise_cnt++;
      oe_rise_at = rise_cnt;
    end
    oe_prev = cmd_oe_o;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC7: remainder of (data * x^7) divided by x^7+x^3+1, by long division.
  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] resp_model(input logic [5:0] idx, input logic [31:0] arg,
                                             input bit no_crc);
    logic [6:0] c;
    c = no_crc ? 7'h7F : crc7_model({2'b00, idx, arg});
    return {2'b00, idx, arg, c, 1'b1};
  endfunction

  int end_rise = 0;

  // Host drives one bit per SDCLK fall, MSB first; optionally checks resp_ready_o
  // drops once the start bit has been sampled.
  task automatic send_frame(input logic [47:0] f, input bit chk_ready_drop);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sdclk_i);
      cmd_i = f[i];
      if (i == 47 && chk_ready_drop) begin
        @(posedge sdclk_i);
        #40;
        check("ready_drop_on_start", resp_ready_o, 1'b0);
      end
    end
    @(negedge sdclk_i);
    cmd_i    = 1'b1;
    end_rise = rise_cnt;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic request(input logic [5:0] idx, input logic [31:0] arg, input bit no_crc);
    int w;
    w = 0;
    while (!resp_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    check("resp_ready_before_req", resp_ready_o, 1'b1);
    resp_index_i  = idx;
    resp_arg_i    = arg;
    resp_no_crc_i = no_crc;
    resp_valid_i  = 1'b1;
    @(negedge clk_i);
    resp_valid_i  = 1'b0;
  endtask

  // Host reads nbits of the response on SDCLK rises; a full read also checks release.
  task automatic get_resp(input int nbits, output logic [47:0] f);
    int w;
    f = '1;
    w = 0;
    @(posedge sdclk_i);
    while (!cmd_oe_o && w < 100) begin
      @(posedge sdclk_i);
      w++;
    end
    check("resp_start_seen", cmd_oe_o, 1'b1);
    if (cmd_oe_o) begin
      f[47] = cmd_o;
      for (int i = 46; i > 47 - nbits; i--) begin
        @(posedge sdclk_i);
        f[i] = cmd_oe_o ? cmd_o : 1'b1;
      end
      if (nbits == 48) begin
        @(posedge sdclk_i);
        check("resp_released", cmd_oe_o, 1'b0);
      end
    end
  endtask

  typedef struct {
    logic [47:0] frame;
    bit          exp_pulse;
    logic [5:0]  exp_index;
    logic [31:0] exp_arg;
    bit          exp_crc_err;
    bit          exp_wait;
  } vec_t;

  vec_t        vec [7];
  logic [47:0] f;
  logic [47:0] exp_f;
  int          p0;
  int          o0;

  initial begin
    // Index/argument are held across discarded frames; CRC-bad handling depends on the build.
    vec[0] = '{48'h40_0000_0000_95, 1'b1, 6'd0,  32'h0000_0000, 1'b0, 1'b1};
    vec[1] = '{48'h48_0000_01AA_87, 1'b1, 6'd8,  32'h0000_01AA, 1'b0, 1'b1};
    vec[2] = '{48'h77_0000_0000_65, 1'b1, 6'd55, 32'h0000_0000, 1'b0, 1'b1};
    vec[3] = '{48'h69_4030_0000_AB, 1'b1, 6'd41, 32'h4030_0000, 1'b0, 1'b1};
    vec[4] = '{48'h00_0000_0000_95, 1'b0, 6'd41, 32'h4030_0000, 1'b0, 1'b0}; // transmission bit clear
    vec[5] = '{48'h40_0000_0000_94, 1'b0, 6'd41, 32'h4030_0000, 1'b0, 1'b0}; // end bit clear
    vec[6] = '{48'h40_0000_0000_97, 1'b1, 6'd0,  32'h0000_0000, CRC_EN, !CRC_EN}; // CRC7 wrong

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_cmd_o", cmd_o, 1'b1);
    check("rst_cmd_oe", cmd_oe_o, 1'b0);
    check("rst_valid", cmd_valid_o, 1'b0);
    check("rst_index", cmd_index_o, 6'd0);
    check("rst_arg", cmd_arg_o, 32'd0);
    check("rst_crc_err", cmd_crc_err_o, 1'b0);
    check("rst_ready", resp_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // Table-driven command decode.
    for (int v = 0; v < 7; v++) begin
      p0 = pulse_cnt;
      send_frame(vec[v].frame, 1'b0);
      check($sformatf("v%0d_pulses", v), 64'(pulse_cnt - p0), 64'(vec[v].exp_pulse));
      check($sformatf("v%0d_index", v), cmd_index_o, vec[v].exp_index);
      check($sformatf("v%0d_arg", v), cmd_arg_o, vec[v].exp_arg);
      if (vec[v].exp_pulse) check($sformatf("v%0d_crc_err", v), cap_crc, vec[v].exp_crc_err);
      check($sformatf("v%0d_ready", v), resp_ready_o, vec[v].exp_wait);
      check($sformatf("v%0d_busy", v), busy_o, vec[v].exp_wait);
    end
    check("crc_bad_never_driven", 64'(oe_rise_cnt), 64'd0);

    // R7 reply to CMD8 with NCR timing.
    send_frame(48'h48_0000_01AA_87, 1'b0);
    request(6'd8, 32'h0000_01AA, 1'b0);
    get_resp(48, f);
    check("r7_frame", f, 48'h08_0000_01AA_13);
    check("r7_frame_model", f, resp_model(6'd8, 32'h0000_01AA, 1'b0));
    check("r7_ncr_rises", 64'(oe_rise_at - end_rise), 64'd2);
    check("r7_idle_after", busy_o, 1'b0);

    // CMD55 + ACMD41 then an R3 reply without CRC.
    send_frame(48'h77_0000_0000_65, 1'b0);
    check("cmd55_index", cmd_index_o, 6'd55);
    send_frame(48'h69_4030_0000_AB, 1'b0);
    check("acmd41_index", cmd_index_o, 6'd41);
    check("acmd41_arg", cmd_arg_o, 32'h4030_0000);
    request(6'h3F, 32'h80FF_8000, 1'b1);
    get_resp(48, f);
    check("r3_frame", f, 48'h3F_80FF_8000_FF);

    // Host abandons a pending response with a new CMD0.
    send_frame(48'h40_0000_0000_95, 1'b0);
    check("abort_ready_before", resp_ready_o, 1'b1);
    p0 = pulse_cnt;
    o0 = oe_rise_cnt;
    send_frame(48'h40_0000_0000_95, 1'b1);
    check("abort_second_pulse", 64'(pulse_cnt - p0), 64'd1);
    check("abort_index", cmd_index_o, 6'd0);
    check("abort_never_driven", 64'(oe_rise_cnt - o0), 64'd0);
    check("abort_ready_again", resp_ready_o, 1'b1);

    // Response request while idle is ignored.
    send_frame(48'h00_0000_0000_95, 1'b0);
    o0 = oe_rise_cnt;
    resp_valid_i = 1'b1;
    @(negedge clk_i);
    resp_valid_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("idle_req_busy", busy_o, 1'b0);
    check("idle_req_no_drive", 64'(oe_rise_cnt - o0), 64'd0);

    // Asynchronous reset in the middle of a response.
    send_frame(48'h48_0000_01AA_87, 1'b0);
    request(6'd8, 32'h0000_01AA, 1'b0);
    get_resp(20, f);
    exp_f = resp_model(6'd8, 32'h0000_01AA, 1'b0);
    check("rst_tx_prefix", f[47:28], exp_f[47:28]);
    check("rst_tx_driving", cmd_oe_o, 1'b1);
    #7;
    rst_ni = 1'b0;
    #1;
    check("rst_tx_oe", cmd_oe_o, 1'b0);
    check("rst_tx_cmd", cmd_o, 1'b1);
    check("rst_tx_index", cmd_index_o, 6'd0);
    check("rst_tx_busy", busy_o, 1'b0);
    #50;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    p0 = pulse_cnt;
    send_frame(48'h40_0000_0000_95, 1'b0);
    check("post_rst_pulse", 64'(pulse_cnt - p0), 64'd1);
    check("post_rst_index", cmd_index_o, 6'd0);
    check("post_rst_arg", cmd_arg_o, 32'd0);
    check("post_rst_ready", resp_ready_o, 1'b1);

    // Randomised commands and responses against the reference model.
    for (int n = 0; n < 8; n++) begin
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [5:0]  ridx;
      logic [31:0] rarg;
      bit          bad;
      bit          rnoc;
      logic [47:0] cf;
      idx  = 6'($urandom);
      arg  = $urandom;
      bad  = ($urandom_range(0, 3) == 0);
      cf   = cmd_frame(idx, arg);
      if (bad) cf[7:1] = cf[7:1] ^ 7'($urandom_range(1, 127));
      p0 = pulse_cnt;
      send_frame(cf, 1'b0);
      check($sformatf("rnd%0d_pulse", n), 64'(pulse_cnt - p0), 64'd1);
      check($sformatf("rnd%0d_index", n), cmd_index_o, idx);
      check($sformatf("rnd%0d_arg", n), cmd_arg_o, arg);
      check($sformatf("rnd%0d_crc_err", n), cap_crc, CRC_EN && bad);
      check($sformatf("rnd%0d_ready", n), resp_ready_o, !(CRC_EN && bad));
      if (!(CRC_EN && bad) && $urandom_range(0, 1) == 1) begin
        ridx = 6'($urandom);
        rarg = $urandom;
        rnoc = ($urandom_range(0, 3) == 0);
        request(ridx, rarg, rnoc);
        get_resp(48, f);
        check($sformatf("rnd%0d_resp", n), f, resp_model(ridx, rarg, rnoc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
